// File: rtl/div_radix2_unit_if.sv
// Divide request/response bundle between the ALU (master) and the divider.
// The ALU drives the request; the divider returns result and done.
interface div_radix2_unit_if #(
    parameter int WIDTH = 32
);
    logic [1:0]         div_op;
    logic [WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]   divisor;
    logic [2*WIDTH-1:0] result;
    logic               done;

    modport master (
        output div_op, dividend, divisor,
        input  result, done
    );

    modport slave (
        input  div_op, dividend, divisor,
        output result, done
    );
endinterface

// File: rtl/div_radix2_unit.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU.
// Produces {remainder, quotient}; done low while a division runs.
module div_radix2_unit #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    div_radix2_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIX
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic [CW-1:0]      r_cnt;
    logic               r_qneg;
    logic               r_rneg;
    logic               r_done;
    logic [2*WIDTH-1:0] r_result;

    logic               w_req;
    logic               w_sgn;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic               w_fit;
    logic               w_last;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_fix;

    assign w_req   = (bus.div_op == 2'b01) || (bus.div_op == 2'b10);
    assign w_sgn   = (bus.div_op == 2'b10);
    assign w_a_neg = w_sgn & bus.dividend[WIDTH-1];
    assign w_b_neg = w_sgn & bus.divisor[WIDTH-1];
    assign w_abs_a = w_a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    assign w_abs_b = w_b_neg ? (~bus.divisor + 1'b1) : bus.divisor;

    // Trial subtraction keeps one extra bit so the borrow decides the step.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_div};
    assign w_fit    = ~w_trial[WIDTH];
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    assign w_rem_fix = r_rneg ? (~r_rem + 1'b1) : r_rem;
    assign w_quo_fix = r_qneg ? (~r_quo + 1'b1) : r_quo;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_req) w_next = S_BUSY;
            S_BUSY:  if (w_last) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_rem  <= '0;
                        r_quo  <= w_abs_a;
                        r_div  <= w_abs_b;
                        r_cnt  <= '0;
                        r_qneg <= w_a_neg ^ w_b_neg;
                        r_rneg <= w_a_neg;
                        r_done <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_rem <= w_fit ? w_trial[WIDTH-1:0]
                                   : w_rem_sh[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_fit};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_result <= {w_rem_fix, w_quo_fix};
                    r_done   <= 1'b1;
                end
                default: r_done <= 1'b1;
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.done   = r_done;
endmodule

// File: tb/tb_div_radix2_unit.sv
// Directed bench for div_radix2_unit: latency, signs, edge values,
// busy-time requests, mid-op reset and a short model-checked sweep.
module tb_div_radix2_unit;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    div_radix2_unit_if #(.WIDTH(32)) bus ();

    div_radix2_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle request; returns just after the accepting edge.
    task automatic req(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
        bus.div_op   = op;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.div_op = 2'b00;
    endtask

    // Wait for done with a bound; reports cycles and result stability.
    task automatic wait_done(output int cyc, output bit stable);
        logic [63:0] hold;
        hold   = bus.result;
        cyc    = 0;
        stable = 1'b1;
        while (!bus.done && cyc < 100) begin
            tick();
            cyc++;
            if (!bus.done && bus.result !== hold) stable = 1'b0;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
        int cyc;
        bit st;
        req(op, a, b);
        wait_done(cyc, st);
        chk({tag, "_res"}, bus.result, exp);
        chk({tag, "_lat"}, 64'(cyc), 64'd33);
        chk({tag, "_stable"}, 64'(st), 64'd1);
    endtask

    initial begin
        int          cyc;
        int          rises;
        bit          st;
        logic        prev;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic [1:0]  op;

        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.div_op   = 2'b00;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_done", 64'(bus.done), 64'd1);
        chk("rst_result", bus.result, 64'h0);

        req(2'b11, 32'd100, 32'd7);
        chk("op11_ignored", 64'(bus.done), 64'd1);

        req(2'b01, 32'd100, 32'd7);
        chk("busy_done_low", 64'(bus.done), 64'd0);
        wait_done(cyc, st);
        chk("divu_100_7", bus.result, 64'h00000002_0000000E);
        chk("divu_100_7_lat", 64'(cyc), 64'd33);
        chk("divu_100_7_stable", 64'(st), 64'd1);
        tick();
        tick();
        chk("divu_100_7_hold", bus.result, 64'h00000002_0000000E);

        run("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2,
            64'hFFFFFFFF_FFFFFFFD);
        run("div_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE,
            64'h00000001_FFFFFFFD);
        run("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF,
            64'h00000000_80000000);
        run("divu_max_1", 2'b01, 32'hFFFFFFFF, 32'd1,
            64'h00000000_FFFFFFFF);
        run("divu_5_0", 2'b01, 32'd5, 32'd0,
            64'h00000005_FFFFFFFF);

        // Requests while busy must be ignored.
        req(2'b01, 32'd100, 32'd7);
        rises = 0;
        prev  = bus.done;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5 || k == 20) begin
                bus.div_op   = 2'b10;
                bus.dividend = 32'd9;
                bus.divisor  = 32'd3;
            end else begin
                bus.div_op = 2'b00;
            end
            tick();
            if (bus.done && !prev) rises++;
            prev = bus.done;
        end
        bus.div_op = 2'b00;
        chk("busy_req_res", bus.result, 64'h00000002_0000000E);
        chk("busy_req_rises", 64'(rises), 64'd1);
        run("after_busy", 2'b10, 32'd9, 32'd3, 64'h00000000_00000003);

        // Reset in the middle of a division.
        req(2'b01, 32'd1000, 32'd3);
        for (int k = 0; k < 9; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_done", 64'(bus.done), 64'd1);
        chk("midrst_result", bus.result, 64'h0);
        run("post_rst", 2'b01, 32'd9, 32'd4, 64'h00000001_00000002);

        for (int i = 0; i < 40; i++) begin
            op = (i % 2 == 0) ? 2'b01 : 2'b10;
            a  = $urandom;
            b  = $urandom;
            if (i % 4 == 1) b = b >> 24;
            if (b == 32'd0) b = 32'd1;
            if (op == 2'b10 && a == 32'h80000000 && b == 32'hFFFFFFFF)
                b = 32'd3;
            if (op == 2'b01) begin
                q = a / b;
                r = a % b;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
            req(op, a, b);
            wait_done(cyc, st);
            chk("rand", bus.result, {r, q});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/div_radix2_unit.md
Name: div_radix2_unit

Overview:
- Multi-cycle restoring radix-2 integer divider; the responder side of the ALU's divide request interface (div_op/divisor/dividend in, result/done out).
- Serves MIPS DIV and DIVU and produces {HI=remainder, LO=quotient}.
- The ALU pipeline treats `done` low as "divider running". It commits the result to HI/LO on the rising edge of `done`.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH. All values below assume 32.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- div_op  in  2  request: 2'b10 signed (DIV), 2'b01 unsigned (DIVU), 2'b00 and 2'b11 no request
- dividend  in  32  numerator (rs)
- divisor  in  32  denominator (rt)
- result  out  64  [63:32] remainder (HI), [31:0] quotient (LO)
- done  out  1  1 = idle with the result valid and stable; 0 = division in progress

Behaviour:
- Reset (clk edge with rst=1): state IDLE, result=64'h0, done=1, iteration counter=0, internal registers cleared. rst overrides any request sampled on the same edge.
- States: IDLE, BUSY, FIX.
- IDLE:
  - done=1, result holds the last value.
  - At an edge with div_op in {01,10}: capture operands; go to BUSY; counter=0.
  - Captured values: |dividend| and |divisor| (two's-complement magnitude when signed; raw when unsigned), the quotient sign q_neg = a[31]^b[31] (signed only), and the remainder sign r_neg = a[31] (signed only).
  - div_op 2'b11 is ignored.
- BUSY:
  - One restoring step per edge: shift {rem,quo} left by 1; trial = rem - |divisor| (33-bit). If trial is non-negative, rem = trial and quo[0] = 1; otherwise quo[0] = 0.
  - After 32 steps (counter==31 at the edge), go to FIX.
- FIX:
  - On the edge, write result = {q_neg ? -rem... } with the rule: remainder = r_neg ? -rem : rem; quotient = q_neg ? -quo : quo. Then go to IDLE; done=1 after this edge.
- Latency:
  - Request sampled at edge E0. done=0 in the cycles after E0 through E33. result updates and done returns to 1 at E33.
  - done is low for exactly 33 cycles.
  - Exactly one done rising edge per accepted request.
- result must not change while done=0. It changes only at the FIX edge or at reset.
- div_op nonzero while BUSY/FIX: ignored. Operands are not resampled, and no queueing occurs.
- Divide by zero: the algorithm runs normally with no exception.
  - Unsigned: result = {dividend, 32'hFFFF_FFFF}.
  - Signed: uses magnitudes and then applies sign fixup as above (deterministic, not architecturally defined).
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: quotient=0x8000_0000, remainder=0. This falls out naturally because the negation wraps.
- Arithmetic is modulo 2^32 for negation; the trial subtraction is 33 bits to preserve the borrow.
- Reset mid-operation: on the next rst edge, abort to IDLE with done=1 and result=0. No commit pulse is generated other than done's natural 0->1 transition.
- Back-to-back requests: a new request may be accepted at the first edge where the state is IDLE (the edge after E33 at the earliest).
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
- DIVU 100/7: div_op=01, dividend=100, divisor=7, one cycle. Expect done=0 for 33 cycles, then done=1 and result=64'h00000002_0000000E, stable afterwards.
- DIV -7/2: div_op=10, dividend=32'hFFFFFFF9, divisor=2. Expect result=64'hFFFFFFFF_FFFFFFFD (r=-1, q=-3). Also 7/-2 gives result=64'h00000001_FFFFFFFD.
- Edge values:
  - DIV 0x80000000/0xFFFFFFFF gives result=64'h00000000_80000000.
  - DIVU 0xFFFFFFFF/1 gives 64'h00000000_FFFFFFFF.
  - DIVU 5/0 gives 64'h00000005_FFFFFFFF.
- Request while busy: start DIVU 100/7, then drive div_op=10 with 9/3 at cycles 5 and 20. Expect the single result 64'h00000002_0000000E and exactly one done rise. A request after done=1 then gives 64'h00000000_00000003.
- Reset mid-op: start DIVU 1000/3, assert rst at cycle 10. The next cycle shows done=1 and result=0. A new DIVU 9/4 then completes in 33 cycles with 64'h00000001_00000002.
- Random: 10k random signed and unsigned pairs with nonzero divisor, checked against a reference model. Invariants: quotient*divisor + remainder == dividend; |remainder| < |divisor|; remainder sign == dividend sign (or remainder==0).
